hadamard_sequencer: RTL and testbench

- Holds an N-qubit real-amplitude state vector (Q16.16) in an internal register file.
- On command, applies the single-qubit Hadamard to a chosen target qubit across every amplitude pair, time-sharing one hadamard_gate instance.
- Sits between the host/test controller and the gate datapath: the first step of Bell-state preparation (H on q0, before CNOT).

---
 rtl/quantum_pkg.sv | 8 +
 rtl/fixed_point_add.sv | 15 +
 rtl/fixed_point_mult.sv | 16 +
 rtl/hadamard_gate.sv | 18 +
 rtl/hadamard_sequencer.sv | 87 ++++++++
 tb/tb_hadamard_sequencer.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/quantum_pkg.sv
// quantum_pkg: shared Q16.16 amplitude constants and sequencer state encoding
package quantum_pkg;
  localparam int AMP_W = 32;
  localparam int FRAC = 16;
  localparam logic [AMP_W-1:0] ONE = 32'h0001_0000;
  localparam logic [AMP_W-1:0] INV_SQRT2 = 32'h0000_B505;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FINISH} state_t;
endpackage

// File: rtl/fixed_point_add.sv
// fixed_point_add: Q16.16 add/subtract with signed overflow flag
module fixed_point_add
  import quantum_pkg::*;
(
  input  logic [AMP_W-1:0] i_a,
  input  logic [AMP_W-1:0] i_b,
  input  logic             i_sub,
  output logic [AMP_W-1:0] o_sum,
  output logic             o_ovf
);
  logic w_bs;
  assign o_sum = i_sub ? i_a - i_b : i_a + i_b;
  assign w_bs = i_b[AMP_W-1] ^ i_sub;
  assign o_ovf = (i_a[AMP_W-1] == w_bs) && (o_sum[AMP_W-1] != i_a[AMP_W-1]);
endmodule

// File: rtl/fixed_point_mult.sv
// fixed_point_mult: truncating signed Q16.16 multiply with overflow flag
module fixed_point_mult
  import quantum_pkg::*;
(
  input  logic [AMP_W-1:0] i_a,
  input  logic [AMP_W-1:0] i_b,
  output logic [AMP_W-1:0] o_p,
  output logic             o_ovf
);
  logic [2*AMP_W-1:0] w_full;
  logic [AMP_W-FRAC:0] w_top;
  assign w_full = {{AMP_W{i_a[AMP_W-1]}}, i_a} * {{AMP_W{i_b[AMP_W-1]}}, i_b};
  assign o_p = AMP_W'(w_full >> FRAC);
  assign w_top = w_full[2*AMP_W-1:AMP_W+FRAC-1];
  assign o_ovf = !(&w_top) && (|w_top);
endmodule

// File: rtl/hadamard_gate.sv
// hadamard_gate: (a+b)/sqrt2 and (a-b)/sqrt2 in Q16.16, overflow from any stage
module hadamard_gate
  import quantum_pkg::*;
(
  input  logic [AMP_W-1:0] i_alpha,
  input  logic [AMP_W-1:0] i_beta,
  output logic [AMP_W-1:0] o_alpha,
  output logic [AMP_W-1:0] o_beta,
  output logic             o_ovf
);
  logic [AMP_W-1:0] w_sum, w_dif;
  logic w_ov_s, w_ov_d, w_ov_a, w_ov_b;
  fixed_point_add u_sum (.i_a(i_alpha), .i_b(i_beta), .i_sub(1'b0), .o_sum(w_sum), .o_ovf(w_ov_s));
  fixed_point_add u_dif (.i_a(i_alpha), .i_b(i_beta), .i_sub(1'b1), .o_sum(w_dif), .o_ovf(w_ov_d));
  fixed_point_mult u_ma (.i_a(w_sum), .i_b(INV_SQRT2), .o_p(o_alpha), .o_ovf(w_ov_a));
  fixed_point_mult u_mb (.i_a(w_dif), .i_b(INV_SQRT2), .o_p(o_beta), .o_ovf(w_ov_b));
  assign o_ovf = w_ov_s | w_ov_d | w_ov_a | w_ov_b;
endmodule

// File: rtl/hadamard_sequencer.sv
// hadamard_sequencer: applies H to one target qubit over a stored state vector,
// time-sharing a single hadamard_gate across all amplitude pairs.
module hadamard_sequencer
  import quantum_pkg::*;
#(
  parameter int NUM_QUBITS = 2,
  localparam int TGT_W = $clog2(NUM_QUBITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [NUM_QUBITS-1:0] wr_addr,
  input  logic [AMP_W-1:0]      wr_data,
  input  logic [NUM_QUBITS-1:0] rd_addr,
  output logic [AMP_W-1:0]      rd_data,
  input  logic                  start,
  input  logic [TGT_W-1:0]      target,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  overflow
);
  localparam int N_AMP = 1 << NUM_QUBITS;
  localparam int K_W = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'((1 << (NUM_QUBITS - 1)) - 1);
  // target carries a spare bit so out-of-range qubit indices can be flagged
  function automatic logic [NUM_QUBITS-1:0] pair_lo(input logic [K_W-1:0] k, input logic [TGT_W-1:0] t);
    logic [NUM_QUBITS-1:0] kz, m;
    kz = NUM_QUBITS'(k);
    m = (NUM_QUBITS'(1) << t) - NUM_QUBITS'(1);
    return ((kz & ~m) << 1) | (kz & m);
  endfunction
  logic [AMP_W-1:0] r_amp [N_AMP];
  logic [AMP_W-1:0] r_a, r_b;
  logic [K_W-1:0] r_k;
  logic [TGT_W-1:0] r_tgt;
  logic r_err, r_ovf;
  state_t r_state, w_next;
  logic [NUM_QUBITS-1:0] w_i, w_j;
  logic [AMP_W-1:0] w_alpha, w_beta;
  logic w_gov, w_legal;
  hadamard_gate u_gate (.i_alpha(r_a), .i_beta(r_b), .o_alpha(w_alpha), .o_beta(w_beta), .o_ovf(w_gov));
  assign w_legal = target < TGT_W'(NUM_QUBITS);
  assign w_i = pair_lo(r_k, r_tgt);
  assign w_j = w_i | (NUM_QUBITS'(1) << r_tgt);
  always_comb begin
    w_next = (r_state == S_IDLE)  ? (start ? (w_legal ? S_FETCH : S_FINISH) : S_IDLE) :
             (r_state == S_FETCH) ? S_WRITE :
             (r_state == S_WRITE) ? ((r_k == K_LAST) ? S_FINISH : S_FETCH) : S_IDLE;
    busy = (r_state == S_FETCH) || (r_state == S_WRITE);
    done = r_state == S_FINISH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k <= '0;
      r_tgt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
      for (int n = 0; n < N_AMP; n++) r_amp[n] <= (n == 0) ? ONE : '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && wr_en) r_amp[wr_addr] <= wr_data;
      if (r_state == S_IDLE && start) begin
        r_err <= !w_legal;
        r_ovf <= 1'b0;
        r_tgt <= target;
        r_k <= '0;
      end
      if (r_state == S_FETCH) begin
        r_a <= r_amp[w_i];
        r_b <= r_amp[w_j];
      end
      if (r_state == S_WRITE) begin
        r_amp[w_i] <= w_alpha;
        r_amp[w_j] <= w_beta;
        r_ovf <= r_ovf | w_gov;
        r_k <= r_k + K_W'(1);
      end
    end
  end
  assign rd_data = r_amp[rd_addr];
  assign err = r_err;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_hadamard_sequencer.sv
// tb_hadamard_sequencer: table-driven H vectors plus hand sequences for
// back-to-back ops, sticky overflow, ignored host traffic and mid-op reset.
module tb_hadamard_sequencer;
  logic clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [1:0] wr_addr = 0, rd_addr = 0, target = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic busy, done, err, overflow;
  int n_vec = 0, n_bad = 0;
  int lat, nb, nd;
  hadamard_sequencer #(.NUM_QUBITS(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .target(target),
    .busy(busy), .done(done), .err(err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [0:3][31:0] pre;
    logic [1:0]       tgt;
    logic [0:3][31:0] exp;
    logic             err;
    logic             ovf;
    logic [3:0]       lat;
    logic [2:0]       nb;
  } vec_t;
  vec_t vt [7];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] e);
    rd_addr = a;
    #1;
    chk(nm, rd_data, e);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic run_op(input logic [1:0] t, output int l, output int b);
    start = 1;
    target = t;
    tick;
    start = 0;
    wr_en = 0;
    l = 1;
    b = int'(busy);
    while (!done && l < 20) begin
      tick;
      l++;
      b += int'(busy);
    end
  endtask
  initial begin
    vt[0] = {{32'h00010000, 32'h0, 32'h0, 32'h0}, 2'd0, {32'h0000B505, 32'h0000B505, 32'h0, 32'h0}, 1'b0, 1'b0, 4'd5, 3'd4};
    vt[1] = {{32'h0000B505, 32'h0, 32'h0000B505, 32'h0}, 2'd1, {32'h00010000, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 4'd5, 3'd4};
    vt[2] = {{32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h0}, 2'd0, {32'hFFFE95F6, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1, 4'd5, 3'd4};
    vt[3] = {{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 2'd2, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b1, 1'b0, 4'd1, 3'd0};
    vt[4] = {{32'h00010000, 32'h00010000, 32'h00008000, 32'hFFFF8000}, 2'd0, {32'h00016A0A, 32'h0, 32'h0, 32'h0000B505}, 1'b0, 1'b0, 4'd5, 3'd4};
    vt[5] = {{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 2'd3, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b1, 1'b0, 4'd1, 3'd0};
    vt[6] = {{32'h00010000, 32'h00020000, 32'h00030000, 32'h0}, 2'd1, {32'h0002D414, 32'h00016A0A, 32'hFFFE95F6, 32'h00016A0A}, 1'b0, 1'b0, 4'd5, 3'd4};
    do_reset;
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst ovf", 32'(overflow), 32'h0);
    rd_chk("rst amp0", 2'd0, 32'h00010000);
    rd_chk("rst amp1", 2'd1, 32'h0);
    rd_chk("rst amp2", 2'd2, 32'h0);
    rd_chk("rst amp3", 2'd3, 32'h0);
    tick;
    for (int v = 0; v < 7; v++) begin
      for (int a = 0; a < 4; a++) wr(2'(a), vt[v].pre[a]);
      run_op(vt[v].tgt, lat, nb);
      chk($sformatf("v%0d latency", v), 32'(lat), 32'(vt[v].lat));
      chk($sformatf("v%0d busy cycles", v), 32'(nb), 32'(vt[v].nb));
      chk($sformatf("v%0d err", v), 32'(err), 32'(vt[v].err));
      chk($sformatf("v%0d ovf", v), 32'(overflow), 32'(vt[v].ovf));
      for (int a = 0; a < 4; a++) rd_chk($sformatf("v%0d amp%0d", v, a), 2'(a), vt[v].exp[a]);
      tick;
    end
    // H on q1 twice from |00> restores the basis state
    do_reset;
    run_op(2'd1, lat, nb);
    tick;
    run_op(2'd1, lat, nb);
    chk("hh latency", 32'(lat), 32'd5);
    chk("hh err", 32'(err), 32'h0);
    rd_chk("hh amp0", 2'd0, 32'h00010000);
    rd_chk("hh amp1", 2'd1, 32'h0);
    rd_chk("hh amp2", 2'd2, 32'h0);
    rd_chk("hh amp3", 2'd3, 32'h0);
    tick;
    // overflow stays set in IDLE, cleared by next accepted start
    wr(2'd0, 32'h7FFF0000);
    wr(2'd1, 32'h7FFF0000);
    run_op(2'd0, lat, nb);
    tick;
    tick;
    tick;
    chk("ovf sticky", 32'(overflow), 32'h1);
    start = 1;
    target = 2'd1;
    tick;
    start = 0;
    chk("ovf cleared", 32'(overflow), 32'h0);
    chk("ovf busy", 32'(busy), 32'h1);
    nd = 0;
    while (!done && nd < 20) begin
      tick;
      nd++;
    end
    chk("ovf done seen", 32'(done), 32'h1);
    tick;
    // write and start in the same IDLE cycle: FETCH sees the new amp1
    do_reset;
    wr_en = 1;
    wr_addr = 2'd1;
    wr_data = 32'h00010000;
    run_op(2'd0, lat, nb);
    chk("wrstart latency", 32'(lat), 32'd5);
    rd_chk("wrstart amp0", 2'd0, 32'h00016A0A);
    rd_chk("wrstart amp1", 2'd1, 32'h0);
    tick;
    // host writes and starts during busy/FINISH are ignored
    do_reset;
    start = 1;
    target = 2'd0;
    tick;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      wr_en = 1;
      wr_addr = 2'd3;
      wr_data = 32'h12345678;
      start = 1;
      target = 2'd0;
      tick;
      nd += int'(done);
    end
    wr_en = 0;
    start = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      nd += int'(done);
    end
    chk("busy ignore done count", 32'(nd), 32'd1);
    chk("busy ignore idle", 32'(busy), 32'h0);
    rd_chk("busy ignore amp3", 2'd3, 32'h0);
    rd_chk("busy ignore amp0", 2'd0, 32'h0000B505);
    tick;
    // reset mid-operation discards the partial result without done
    wr(2'd1, 32'h00040000);
    start = 1;
    target = 2'd0;
    tick;
    start = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    nd = int'(done);
    for (int c = 0; c < 8; c++) begin
      tick;
      nd += int'(done);
    end
    chk("midrst done count", 32'(nd), 32'd0);
    chk("midrst busy", 32'(busy), 32'h0);
    rd_chk("midrst amp0", 2'd0, 32'h00010000);
    rd_chk("midrst amp1", 2'd1, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
